// File: rtl/nibble_deserializer_if.sv
// Handshake and serial bus bundle between the nibble deserializer and its sender/consumer.
// Carries parity_err only when NIBBLE_DESER_PARITY_EN is defined.
interface nibble_deserializer_if #(
    parameter int unsigned NIBBLE_W = 4
);
    logic                start;
    logic                bit_valid;
    logic                serial_in;
    logic                in_ready;
    logic [NIBBLE_W-1:0] nibble_out;
    logic                out_valid;
    logic                out_ready;
    logic                frame_drop;
    logic                busy;
`ifdef NIBBLE_DESER_PARITY_EN
    logic                parity_err;
`endif

    modport slave (
`ifdef NIBBLE_DESER_PARITY_EN
        output parity_err,
`endif
        input  start, bit_valid, serial_in, out_ready,
        output in_ready, nibble_out, out_valid, frame_drop, busy
    );

    modport master (
`ifdef NIBBLE_DESER_PARITY_EN
        input  parity_err,
`endif
        output start, bit_valid, serial_in, out_ready,
        input  in_ready, nibble_out, out_valid, frame_drop, busy
    );
endinterface

// File: rtl/nibble_deserializer.sv
// Framed serial-to-parallel front end holding each word behind a valid/ready handshake.
// Optional even-parity slot after the data bits: define NIBBLE_DESER_PARITY_EN.
module nibble_deserializer #(
    parameter int unsigned NIBBLE_W  = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    nibble_deserializer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [3:0] NW        = 4'(NIBBLE_W);
    localparam logic [3:0] LAST_DATA = 4'(NIBBLE_W - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d, cnt_base;
    logic [NIBBLE_W-1:0] sh_q, sh_d, sh_base, sh_ins;
    logic [NIBBLE_W-1:0] nib_q, nib_d;
    logic                drop_q, drop_d;
`ifdef NIBBLE_DESER_PARITY_EN
    logic                par_q, par_d, par_base;
    logic                perr_q, perr_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            nib_q   <= '0;
            drop_q  <= 1'b0;
`ifdef NIBBLE_DESER_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            nib_q   <= nib_d;
            drop_q  <= drop_d;
`ifdef NIBBLE_DESER_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // A start strobe restarts the frame, so the incoming bit lands against a cleared base.
    always_comb begin
        cnt_base = bus.start ? '0 : cnt_q;
        sh_base  = bus.start ? '0 : sh_q;
`ifdef NIBBLE_DESER_PARITY_EN
        par_base = bus.start ? 1'b0 : par_q;
`endif
        sh_ins = sh_base;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            if (cnt_base == 4'(LSB_FIRST ? i : NIBBLE_W - 1 - i))
                sh_ins[i] = bus.serial_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        nib_d   = nib_q;
        drop_d  = 1'b0;
`ifdef NIBBLE_DESER_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE, SHIFT: begin
                if (state_q == SHIFT || bus.start) begin
                    state_d = SHIFT;
                    drop_d  = (state_q == SHIFT) && bus.start && (cnt_q != '0);
                    cnt_d   = cnt_base;
                    sh_d    = sh_base;
`ifdef NIBBLE_DESER_PARITY_EN
                    par_d   = par_base;
`endif
                    if (bus.bit_valid) begin
                        if (cnt_base < NW) begin
                            sh_d  = sh_ins;
                            cnt_d = cnt_base + 4'd1;
`ifdef NIBBLE_DESER_PARITY_EN
                            par_d = par_base ^ bus.serial_in;
                        end else begin
                            nib_d   = sh_base;
                            perr_d  = par_base ^ bus.serial_in;
                            state_d = DONE;
`else
                            if (cnt_base == LAST_DATA) begin
                                nib_d   = sh_ins;
                                state_d = DONE;
                            end
`endif
                        end
                    end
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q != DONE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.nibble_out = nib_q;
    assign bus.frame_drop = drop_q;
`ifdef NIBBLE_DESER_PARITY_EN
    assign bus.parity_err = perr_q;
`endif
endmodule
